parallel2serial_stream: RTL and testbench
=========================================

Name: parallel2serial_stream

Overview:
- Parametrised successor to the team's fixed 4-bit parallel-to-serial shifter.
- Accepts WIDTH-bit words over a valid/ready input handshake and serialises them one bit per accepted output beat.
- Output order is selectable: MSB-first or LSB-first.
- A one-word holding buffer gives gapless back-to-back frames; downstream backpressure is honoured. Sits between parallel datapath producers and single-wire serial links/encoders.

Parameters:
- WIDTH, 8, bits per parallel word; legal range 2..64; elaboration error outside it.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- din  input  WIDTH  parallel word
- din_valid  input  1  din is valid
- din_ready  output  1  block can accept din this cycle
- dout  output  1  current serial bit
- valid_out  output  1  dout is valid
- out_ready  input  1  downstream consumes dout this cycle
- sof  output  1  dout is the first bit of a word (qualified by valid_out)
- eof  output  1  dout is the last bit of a word (qualified by valid_out)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: rst=1 at a rising edge clears the holding buffer, the shifter, the bit counter and the state.
  - After that edge: din_ready=1, valid_out=0, dout=0, sof=0, eof=0.
  - Reset mid-frame discards all partial and buffered data; no further bits of those words appear.
- Input accept: a word is accepted when din_valid && din_ready at a rising edge.
  - din_ready = !buf_full, registered; it does not depend combinationally on din_valid.
- Holding buffer (buf): captures din on accept; buf_full=1.
- States, held in a shared enum:
  - IDLE: shifter empty.
  - SHIFT: shifter loaded, word in progress.
- IDLE -> SHIFT: if buf_full, the shifter loads buf at the next edge, buf_full->0 and cnt->0.
  - Latency: word accepted at edge N, first bit valid after edge N+1.
- Output beat: in SHIFT, valid_out=1. A beat completes at an edge where out_ready=1.
  - On a beat: cnt increments and the shifter shifts toward the output end.
  - When out_ready=0, dout, sof, eof and the shifter hold.
- dout = shifter[WIDTH-1] when MSB_FIRST=1; dout = shifter[0] when MSB_FIRST=0. In IDLE, dout=0.
- sof = valid_out && cnt==0.
- eof = valid_out && cnt==WIDTH-1.
- Last-beat handling (cnt==WIDTH-1 and out_ready=1):
  - If buf_full: reload the shifter from buf in the same edge, cnt->0, stay in SHIFT, buf_full->0. There is no idle bubble between words.
  - Else: go to IDLE and clear valid_out.
- Simultaneous events: an accept into buf and a buf->shifter transfer cannot collide, because accept requires buf_full=0.
  - Result: for WIDTH>=2, a producer holding din_valid=1 sustains 100% output utilisation.
- cnt width: $clog2(WIDTH). Wrap-around happens only through the explicit reset to 0, never by natural overflow.
- din is sampled only on accept; din changes while din_ready=0 have no effect.

Decomposition:
- Package p2s_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - the WIDTH legality bounds (P2S_MIN_WIDTH=2, P2S_MAX_WIDTH=64).
- One natural sub-module: p2s_hold_buf.
  - A one-entry valid/ready register stage holding buf and buf_full.
  - Reused by the team's future serial-path blocks.
- The shifter, cnt and FSM stay in the top module.

Test Plan:
- WIDTH=4, MSB_FIRST=1, out_ready=1; accept din=4'b1011 at edge 0:
  - valid_out rises after edge 1; dout=1,0,1,1 on four consecutive cycles;
  - sof on bit 1, eof on bit 4; then valid_out=0.
- WIDTH=4, MSB_FIRST=1, din_valid held 1 with 4'hA then 4'h5:
  - 8 contiguous valid bits 1,0,1,0,0,1,0,1 with no gap;
  - sof on bits 1 and 5, eof on bits 4 and 8;
  - din_ready=0 while buf_full.
- WIDTH=4, MSB_FIRST=0, din=4'b1011 -> dout=1,1,0,1.
- Backpressure: WIDTH=8, din=8'hC3, out_ready=0 for 3 cycles after bit 2:
  - dout, sof and eof hold; the full sequence is still 1,1,0,0,0,0,1,1;
  - no bit is lost or duplicated.
- Reset mid-frame: assert rst after bit 2 of 4'hA with 4'h5 buffered:
  - next cycle valid_out=0, dout=0, din_ready=1;
  - a new word 4'hF then produces 1,1,1,1 with sof/eof correct.
- WIDTH=2 streaming of 2'b10, 2'b01, 2'b11 -> 1,0,0,1,1,1 contiguous; eof on every second bit.

Source files
------------

// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types and limits for the parallel-to-serial stream path.
//   p2s_state_e   : shifter FSM state (IDLE = shifter empty, SHIFT = word in flight)
//   P2S_MIN_WIDTH : smallest legal word width
//   P2S_MAX_WIDTH : largest legal word width
package p2s_pkg;

  localparam int P2S_MIN_WIDTH = 2;
  localparam int P2S_MAX_WIDTH = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_e;

endpackage

// File: rtl/p2s_hold_buf.sv
// p2s_hold_buf: one-entry valid/ready register stage.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_valid  : upstream word and its valid
//   in_ready          : registered, high while the entry is empty
//   buf_data/buf_full : held word and occupancy flag
//   pop               : consumer takes the held word this edge
// Fill requires empty and pop requires full, so they never coincide.
module p2s_hold_buf
  import p2s_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] buf_data,
  output logic         buf_full,
  input  logic         pop
);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else if (in_valid && !buf_full) begin
      buf_data <= in_data;
      buf_full <= 1'b1;
    end else if (pop) begin
      buf_full <= 1'b0;
    end
  end

  assign in_ready = !buf_full;

endmodule

// File: rtl/parallel2serial_stream.sv
// parallel2serial_stream: serialises WIDTH-bit words one bit per output beat.
//   clk, rst             : clock, synchronous active-high reset
//   din/din_valid        : parallel word in, valid
//   din_ready            : registered, high while the holding buffer is empty
//   dout/valid_out       : serial bit and its valid
//   out_ready            : downstream takes dout this cycle
//   sof/eof              : first/last bit of a word (qualified by valid_out)
// The holding buffer lets the next word reload the shifter on the last beat,
// so back-to-back words stream with no idle cycle.
module parallel2serial_stream
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             valid_out,
  input  logic             out_ready,
  output logic             sof,
  output logic             eof
);

  generate
    if (WIDTH < P2S_MIN_WIDTH || WIDTH > P2S_MAX_WIDTH) begin : g_bad_width
      $error("parallel2serial_stream: WIDTH %0d outside legal range", WIDTH);
    end
  endgenerate

  localparam int               CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam int               OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  p2s_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic             last_beat;
  logic             pop;

  p2s_hold_buf #(.W(WIDTH)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (din),
    .in_valid (din_valid),
    .in_ready (din_ready),
    .buf_data (buf_data),
    .buf_full (buf_full),
    .pop      (pop)
  );

  // Shift toward the output end; the vacated end fills with zero.
  assign shifted   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  assign last_beat = (state == SHIFT) && out_ready && (cnt == LAST);
  // Buffer drains into the shifter when it is empty or finishing its last bit.
  assign pop       = buf_full && ((state == IDLE) || last_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (buf_full) begin
            shreg <= buf_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (buf_full) begin
                shreg <= buf_data;
              end else begin
                shreg <= '0;
                state <= IDLE;
              end
            end else begin
              shreg <= shifted;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid_out = (state == SHIFT);
  assign dout      = valid_out && shreg[OUT_IDX];
  assign sof       = valid_out && (cnt == '0);
  assign eof       = valid_out && (cnt == LAST);

endmodule

// File: tb/tb_parallel2serial_stream.sv
// tb_parallel2serial_stream: directed checks of four configurations
// (W4 MSB-first, W4 LSB-first, W8 MSB-first, W2 MSB-first) sharing one
// word feeder; sel picks which instance the checks observe.
module tb_parallel2serial_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] cur = '0;
  logic [63:0] q[$];
  int          sel = 0;
  int          total = 0;
  int          bad = 0;

  logic [3:0] rdy_a, vo_a, d_a, s_a, e_a;
  logic       rdy, vo, d, s, e;

  always #5 clk = ~clk;

  parallel2serial_stream #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (
    .clk(clk), .rst(rst), .din(cur[3:0]), .din_valid(din_valid), .din_ready(rdy_a[0]),
    .dout(d_a[0]), .valid_out(vo_a[0]), .out_ready(out_ready), .sof(s_a[0]), .eof(e_a[0]));
  parallel2serial_stream #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (
    .clk(clk), .rst(rst), .din(cur[3:0]), .din_valid(din_valid), .din_ready(rdy_a[1]),
    .dout(d_a[1]), .valid_out(vo_a[1]), .out_ready(out_ready), .sof(s_a[1]), .eof(e_a[1]));
  parallel2serial_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst(rst), .din(cur[7:0]), .din_valid(din_valid), .din_ready(rdy_a[2]),
    .dout(d_a[2]), .valid_out(vo_a[2]), .out_ready(out_ready), .sof(s_a[2]), .eof(e_a[2]));
  parallel2serial_stream #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .din(cur[1:0]), .din_valid(din_valid), .din_ready(rdy_a[3]),
    .dout(d_a[3]), .valid_out(vo_a[3]), .out_ready(out_ready), .sof(s_a[3]), .eof(e_a[3]));

  always_comb begin
    rdy = rdy_a[sel];
    vo  = vo_a[sel];
    d   = d_a[sel];
    s   = s_a[sel];
    e   = e_a[sel];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; on an accept by the observed instance the feeder advances.
  task automatic tick();
    logic acc;
    acc = din_valid && rdy && !rst;
    @(posedge clk);
    #1;
    if (acc) begin
      if (q.size() > 0) cur = q.pop_front();
      else din_valid = 1'b0;
    end
  endtask

  task automatic start();
    cur = q.pop_front();
    din_valid = 1'b1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    out_ready = 1'b1;
    q.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Checks n contiguous beats; exp holds the first bit at position n-1.
  task automatic run_seq(input string tag, input int w, input int n, input logic [63:0] exp,
                         input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      logic eb, es, ee;
      eb = exp[n-1-i];
      es = (i % w == 0);
      ee = (i % w == w - 1);
      chk({tag, "_vo"}, 64'(vo), 64'd1);
      chk({tag, "_dout"}, 64'(d), 64'(eb));
      chk({tag, "_sof"}, 64'(s), 64'(es));
      chk({tag, "_eof"}, 64'(e), 64'(ee));
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          chk({tag, "_hold_vo"}, 64'(vo), 64'd1);
          chk({tag, "_hold_dout"}, 64'(d), 64'(eb));
          chk({tag, "_hold_sof"}, 64'(s), 64'(es));
          chk({tag, "_hold_eof"}, 64'(e), 64'(ee));
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk({tag, "_end_vo"}, 64'(vo), 64'd0);
    chk({tag, "_end_dout"}, 64'(d), 64'd0);
    chk({tag, "_end_rdy"}, 64'(rdy), 64'd1);
  endtask

  initial begin
    // reset state on every configuration
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #0;
      chk("rst_rdy", 64'(rdy), 64'd1);
      chk("rst_vo", 64'(vo), 64'd0);
      chk("rst_dout", 64'(d), 64'd0);
      chk("rst_sofeof", 64'({s, e}), 64'd0);
    end

    // single word, MSB first, with first-bit latency
    sel = 0;
    do_reset();
    q.push_back(64'b1011);
    start();
    tick();
    chk("t1_lat_vo", 64'(vo), 64'd0);
    chk("t1_full_rdy", 64'(rdy), 64'd0);
    tick();
    run_seq("t1", 4, 4, 64'b1011, -1, 0);

    // back-to-back words, no bubble
    sel = 0;
    do_reset();
    q.push_back(64'hA);
    q.push_back(64'h5);
    start();
    tick();
    chk("t2_full_rdy", 64'(rdy), 64'd0);
    tick();
    run_seq("t2", 4, 8, 64'b10100101, -1, 0);

    // LSB first
    sel = 1;
    do_reset();
    q.push_back(64'b1011);
    start();
    tick();
    tick();
    run_seq("t3", 4, 4, 64'b1101, -1, 0);

    // backpressure after bit 2
    sel = 2;
    do_reset();
    q.push_back(64'hC3);
    start();
    tick();
    tick();
    run_seq("t4", 8, 8, 64'b11000011, 1, 3);

    // reset mid-frame with a word buffered
    sel = 0;
    do_reset();
    q.push_back(64'hA);
    q.push_back(64'h5);
    start();
    tick();
    tick();
    tick();
    chk("t5_bit2", 64'(d), 64'd0);
    chk("t5_buf_rdy", 64'(rdy), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_vo", 64'(vo), 64'd0);
    chk("t5_rst_dout", 64'(d), 64'd0);
    chk("t5_rst_rdy", 64'(rdy), 64'd1);
    q.push_back(64'hF);
    start();
    tick();
    tick();
    run_seq("t5", 4, 4, 64'b1111, -1, 0);

    // WIDTH=2 streaming
    sel = 3;
    do_reset();
    q.push_back(64'b10);
    q.push_back(64'b01);
    q.push_back(64'b11);
    start();
    tick();
    tick();
    run_seq("t6", 2, 6, 64'b100111, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
